gcd_controller: RTL and testbench
=================================

GCD_CONTROLLER -- requirements
Module: gcd_controller

Interface
REQ-001 Parameter MAX_ITER, default 65535: maximum subtract iterations before abort.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new GCD run; sampled only in IDLE.
REQ-005 in_valid  input  1  operand present on the datapath data_in bus this cycle.
REQ-006 gt / lt / eq  input  1 each  datapath compare flags for A_out vs B_out, combinational from the registers.
REQ-007 in_ready  output  1  controller accepts an operand this cycle.
REQ-008 ldA / ldB  output  1 each  register A / B load enables.
REQ-009 sel  output  1  0: Subout = A-B; 1: Subout = B-A.
REQ-010 sel_in  output  1  1: Bus = data_in; 0: Bus = Subout.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  qualifies done: run aborted at MAX_ITER.
REQ-014 iter_count  output  17  subtract iterations in the current or last run.

Function
REQ-015 States SHALL be IDLE, LOAD_A, LOAD_B, RUN and DONE, with binary encoding and a registered state.
REQ-016 ldA, ldB, sel, sel_in and in_ready SHALL be Mealy outputs, decoded combinationally from the state and the inputs, and SHALL be 0 unless a rule below drives them.
REQ-017 IDLE: on start=1 go to LOAD_A, clear iter_count to 0 and clear the err flag; otherwise hold.
REQ-018 LOAD_A: in_ready=1 and sel_in=1; when in_valid=1, assert ldA=1 and go to LOAD_B; when in_valid=0, hold with ldA=0 and no timeout.
REQ-019 LOAD_B: same as LOAD_A but asserts ldB; on in_valid=1 go to RUN.
REQ-020 RUN: the priority is eq > gt > lt; in_ready=0 and sel_in=0.
REQ-021 RUN, eq=1: no load; go to DONE.
REQ-022 RUN, gt=1 (eq=0): assert ldA=1 with sel=0, which loads A-B; increment iter_count.
REQ-023 RUN, lt=1 (eq=0, gt=0): assert ldB=1 with sel=1, which loads B-A; increment iter_count.
REQ-024 RUN with no flag asserted (illegal input): no load and no increment; hold in RUN.
REQ-025 RUN with iter_count == MAX_ITER and eq=0: set the err flag, perform no load, and go to DONE.
REQ-026 An eq=1 seen in the same cycle as the MAX_ITER condition SHALL win: completion is normal and err=0.
REQ-027 RUN SHALL perform exactly one subtraction per cycle; the compare flags are read the cycle after each load.
REQ-028 DONE: done=1 for exactly one cycle, err equals the err flag, then go to IDLE unconditionally.
REQ-029 After DONE, iter_count SHALL hold its last value until the next accepted start.
REQ-030 iter_count SHALL never exceed MAX_ITER.
REQ-031 start SHALL be ignored in LOAD_A, LOAD_B, RUN and DONE.
REQ-032 A start held high through DONE SHALL begin a new run on the first IDLE cycle.
REQ-033 ldA and ldB SHALL never both be 1 in the same cycle.
REQ-034 ldA or ldB SHALL never be 1 in IDLE or DONE.
REQ-035 Latency: start is accepted at edge N, so LOAD_A is current in cycle N+1.
REQ-036 With in_valid held at 1, RUN is entered at N+3 and done rises k+1 cycles later, where k = iterations.

Reset
REQ-037 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, iter_count=0 and err flag=0.
REQ-038 During reset all outputs SHALL be 0.
REQ-039 Reset asserted mid-run SHALL abandon the run with no done pulse.
REQ-040 Datapath register contents are not cleared by reset.
REQ-041 The first rising clk edge after rst_n deasserts SHALL be evaluated as IDLE.

Verification
REQ-042 Normal run: A=48, B=18, in_valid=1 -> loads A=30, A=12, B=6, A=6; done=1, err=0, iter_count=4, Ans=6.
REQ-043 Equal operands: A=7, B=7 -> RUN sees eq on its first cycle; done 1 cycle later, iter_count=0, Ans=7, no ldA/ldB in RUN.
REQ-044 Zero operand: MAX_ITER=8, A=0, B=5 -> 8 ldB cycles, then done=1, err=1, iter_count=8.
REQ-045 Stall: in_valid=0 for 10 cycles in LOAD_A -> in_ready=1 and ldA=0 throughout; in_valid=1 -> ldA=1, LOAD_B next.
REQ-046 Reset mid-RUN with A=48, B=18 -> all outputs 0 at once, done never pulses; a new start after release -> full run again.
REQ-047 start pulsed during RUN and during DONE -> no effect on the current run.
REQ-048 start held high through DONE -> LOAD_A one cycle after the IDLE cycle.

Source files
------------

// File: rtl/gcd_controller.sv
// -----------------------------------------------------------------------------
// gcd_controller
//
// Control FSM for a subtract-based GCD datapath. The datapath holds two
// registers A and B, a subtractor whose direction is chosen by `sel`, and a
// bus mux choosing between external data (`data_in`) and the subtractor
// output. This controller loads both operands through a valid/ready
// handshake. It then subtracts the smaller register from the larger one,
// one subtraction per cycle, until the datapath reports A == B. A run that
// needs more than MAX_ITER subtractions is aborted and flagged with `err`.
//
// Parameters
//   MAX_ITER    maximum subtract iterations before a run is aborted
//
// Ports
//   clk         single clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   start       request a new run, sampled only while idle
//   in_valid    an operand is present on the datapath data_in bus
//   gt/lt/eq    datapath compare flags for A vs B (combinational)
//   in_ready    controller accepts an operand this cycle
//   ldA/ldB     load enables for datapath registers A / B
//   sel         0: Subout = A-B, 1: Subout = B-A
//   sel_in      1: Bus = data_in, 0: Bus = Subout
//   busy        high in every state except IDLE
//   done        one-cycle completion pulse
//   err         qualifies done: the run was aborted at MAX_ITER
//   iter_count  subtract iterations in the current or the last run
// -----------------------------------------------------------------------------
module gcd_controller #(
  parameter int MAX_ITER = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic        gt,
  input  logic        lt,
  input  logic        eq,
  output logic        in_ready,
  output logic        ldA,
  output logic        ldB,
  output logic        sel,
  output logic        sel_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [16:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [16:0] MAX_CNT = 17'(MAX_ITER);

  state_t      state_q, state_d;
  logic [16:0] iter_q, iter_d;
  logic        err_q, err_d;
  logic        at_max_s;

  // The abort limit is checked against the count of subtractions already
  // performed, so exactly MAX_ITER subtractions are allowed.
  assign at_max_s = (iter_q == MAX_CNT);

  // State, iteration counter and abort flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      iter_q  <= 17'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and Mealy datapath controls.
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    err_d    = err_q;
    in_ready = 1'b0;
    ldA      = 1'b0;
    ldB      = 1'b0;
    sel      = 1'b0;
    sel_in   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_A;
          iter_d  = 17'd0;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD_A: begin
        in_ready = 1'b1;
        sel_in   = 1'b1;
        if (in_valid) begin
          ldA     = 1'b1;
          state_d = S_LOAD_B;
        end else begin
          state_d = S_LOAD_A;
        end
      end

      S_LOAD_B: begin
        in_ready = 1'b1;
        sel_in   = 1'b1;
        if (in_valid) begin
          ldB     = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_LOAD_B;
        end
      end

      S_RUN: begin
        // eq is tested before the limit so an equality reached on the
        // last allowed iteration still completes normally.
        if (eq) begin
          state_d = S_DONE;
        end else if (at_max_s) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (gt) begin
          ldA    = 1'b1;
          sel    = 1'b0;
          iter_d = iter_q + 17'd1;
        end else if (lt) begin
          ldB    = 1'b1;
          sel    = 1'b1;
          iter_d = iter_q + 17'd1;
        end else begin
          // No compare flag at all: wait for the datapath to settle.
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs decode the registered state only, so they are all low
  // while reset holds the state in IDLE.
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_DONE) && err_q;
  assign iter_count = iter_q;

  gcd_controller_chk #(
    .MAX_ITER(MAX_ITER)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .ldA        (ldA),
    .ldB        (ldB),
    .busy       (busy),
    .done       (done),
    .iter_count (iter_count)
  );

endmodule

// -----------------------------------------------------------------------------
// gcd_controller_chk
//
// Structural invariants of the controller outputs. Contains only
// assertions and has no effect on the logic.
//
// Ports
//   clk, rst_n   clock and active-low reset of the observed controller
//   ldA, ldB     register load enables
//   busy, done   status outputs
//   iter_count   iteration counter
// -----------------------------------------------------------------------------
module gcd_controller_chk #(
  parameter int MAX_ITER = 65535
) (
  input logic        clk,
  input logic        rst_n,
  input logic        ldA,
  input logic        ldB,
  input logic        busy,
  input logic        done,
  input logic [16:0] iter_count
);

  localparam logic [16:0] MAX_CNT = 17'(MAX_ITER);

  a_one_load: assert property (@(posedge clk) disable iff (!rst_n)
    !(ldA && ldB));

  a_no_load_idle_done: assert property (@(posedge clk) disable iff (!rst_n)
    !((ldA || ldB) && (!busy || done)));

  a_iter_bound: assert property (@(posedge clk) disable iff (!rst_n)
    iter_count <= MAX_CNT);

endmodule

// File: tb/tb_gcd_controller.sv
// -----------------------------------------------------------------------------
// tb_gcd_controller
//
// Bench for gcd_controller. It contains a small model of the GCD datapath:
// registers A and B, a subtractor and a bus mux. Each run pushes its
// expected result, taken from a plain-arithmetic GCD reference, onto a
// queue. A monitor pops one entry per done pulse and compares err,
// iter_count and the answer left in register A. The run task separately
// checks the handshake timing and the latency.
// -----------------------------------------------------------------------------
module tb_gcd_controller;

  localparam int MAX_ITER = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        gt, lt, eq;
  logic        in_ready, ldA, ldB, sel, sel_in, busy, done, err;
  logic [16:0] iter_count;

  logic [15:0] data_in;
  logic [15:0] a_reg, b_reg;
  logic [15:0] sub_out, bus;

  typedef struct {
    bit err;
    int iters;
    int ans;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  gcd_controller #(.MAX_ITER(MAX_ITER)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .gt         (gt),
    .lt         (lt),
    .eq         (eq),
    .in_ready   (in_ready),
    .ldA        (ldA),
    .ldB        (ldB),
    .sel        (sel),
    .sel_in     (sel_in),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .iter_count (iter_count)
  );

  always #5 clk = ~clk;

  // Datapath model. The registers are deliberately not reset.
  assign sub_out = sel ? (b_reg - a_reg) : (a_reg - b_reg);
  assign bus     = sel_in ? data_in : sub_out;
  assign gt      = (a_reg > b_reg);
  assign lt      = (a_reg < b_reg);
  assign eq      = (a_reg == b_reg);

  always @(posedge clk) begin
    if (ldA) a_reg <= bus;
    if (ldB) b_reg <= bus;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: repeated subtraction of the smaller value from the larger.
  // A run that is still unequal after MAX_ITER subtractions is an abort.
  function automatic void ref_gcd(input int a, input int b,
                                  output bit e_err, output int e_it, output int e_ans);
    int x = a;
    int y = b;
    e_it = 0;
    while (x != y && e_it < MAX_ITER) begin
      if (x > y) x = x - y;
      else       y = y - x;
      e_it++;
    end
    if (x == y) begin
      e_err = 1'b0;
      e_ans = x;
    end else begin
      e_err = 1'b1;
      e_it  = MAX_ITER;
      e_ans = 0;
    end
  endfunction

  task automatic push_exp(input int a, input int b, output int e_it);
    exp_t e;
    ref_gcd(a, b, e.err, e.iters, e.ans);
    e_it = e.iters;
    sb_q.push_back(e);
  endtask

  // Drives one run from the LOAD_A cycle onwards. On entry the current
  // negedge is the first LOAD_A cycle. The timing checks count negedges
  // from that cycle, which is numbered 1.
  task automatic feed(input int a, input int b, input int stall,
                      input bit pulse_start, input bit hold_start, input int exp_it);
    int lat   = 1;
    int loads = 0;
    bit seen  = 1'b0;
    check("load_a_ready", {31'd0, in_ready}, 32'd1);
    check("load_a_sel_in", {31'd0, sel_in}, 32'd1);
    for (int i = 0; i < stall; i++) begin
      check("stall_ready", {31'd0, in_ready}, 32'd1);
      check("stall_no_ldA", {31'd0, ldA}, 32'd0);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b1;
    data_in  = 16'(a);
    #1;
    check("load_a_ldA", {31'd0, ldA}, 32'd1);
    @(negedge clk);
    lat++;
    data_in = 16'(b);
    #1;
    check("load_b_ldB", {30'd0, ldB, in_ready}, 32'd3);
    @(negedge clk);
    lat++;
    in_valid = 1'b0;
    for (int i = 0; i < MAX_ITER + 16 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (ldA || ldB) loads++;
        if (pulse_start) start = (lat == 4);
        @(negedge clk);
        lat++;
      end
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", lat, 4 + stall + exp_it);
      check("run_loads", loads, exp_it);
      if (pulse_start || hold_start) start = 1'b1;
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      check("idle_after_done", {31'd0, busy}, 32'd0);
      if (pulse_start) begin
        @(negedge clk);
        check("start_ignored", {31'd0, busy}, 32'd0);
      end
      if (hold_start) begin
        @(negedge clk);
        start = 1'b0;
        check("held_start_load_a", {30'd0, busy, in_ready}, 32'd3);
      end
    end
  endtask

  task automatic do_run(input int a, input int b, input int stall,
                        input bit pulse_start, input bit hold_start);
    int e_it;
    push_exp(a, b, e_it);
    @(negedge clk);
    start    = 1'b1;
    data_in  = 16'(a);
    in_valid = (stall == 0);
    @(negedge clk);
    start = 1'b0;
    feed(a, b, stall, pulse_start, hold_start, e_it);
  endtask

  // Scoreboard monitor and per-cycle output invariants.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      check("ld_exclusive", {31'd0, ldA & ldB}, 32'd0);
      check("no_load_idle_done", {31'd0, (ldA | ldB) & (~busy | done)}, 32'd0);
      check("err_only_with_done", {31'd0, err & ~done}, 32'd0);
      if (done) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("result_err", {31'd0, err}, {31'd0, e.err});
          check("result_iter_count", {15'd0, iter_count}, e.iters);
          if (!e.err) check("result_ans", {16'd0, a_reg}, e.ans);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin : stimulus
    int e_it;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    data_in  = 16'd0;
    #12;
    check("reset_outputs",
          {15'd0, busy, done, err, in_ready, ldA, ldB, sel, sel_in, iter_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {14'd0, busy, iter_count}, 32'd0);

    // Directed cases: normal run, equal operands, zero operands,
    // and completion exactly at the limit against one step past it.
    do_run(48, 18, 0, 1'b0, 1'b0);
    do_run(7, 7, 0, 1'b0, 1'b0);
    do_run(0, 5, 0, 1'b0, 1'b0);
    do_run(5, 0, 0, 1'b0, 1'b0);
    do_run(9, 1, 0, 1'b0, 1'b0);
    do_run(10, 1, 0, 1'b0, 1'b0);

    // Operand stall in LOAD_A.
    do_run(48, 18, 10, 1'b0, 1'b0);

    // start pulsed in RUN and in DONE.
    do_run(48, 18, 0, 1'b1, 1'b0);

    // start held through DONE begins the next run straight away.
    do_run(48, 18, 0, 1'b0, 1'b1);
    push_exp(21, 6, e_it);
    in_valid = 1'b1;
    data_in  = 16'd21;
    feed(21, 6, 0, 1'b0, 1'b0, e_it);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    start    = 1'b1;
    data_in  = 16'd48;
    in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    data_in = 16'd18;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("run_iter_count", {15'd0, iter_count}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_run_outputs",
          {15'd0, busy, done, err, in_ready, ldA, ldB, sel, sel_in, iter_count}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_idle", {14'd0, busy, iter_count}, 32'd0);
    do_run(48, 18, 0, 1'b0, 1'b0);

    // Random operands and random stalls.
    for (int n = 0; n < 24; n++) begin
      do_run(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
